// File: rtl/core_mem_tag_tracker_if.sv
// Handshake bundle between the core memory mux, the tag tracker and
// the global memory port: upstream req/rsp plus tagged memory req/rsp.
interface core_mem_tag_tracker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 4,
    parameter int TAGS   = 4
);
    localparam int TAG_W = $clog2(TAGS);

    logic              up_req_valid;
    logic              up_req_ready;
    logic              up_req_write;
    logic [ADDR_W-1:0] up_req_addr;
    logic [DATA_W-1:0] up_req_data;
    logic [SRC_W-1:0]  up_req_src;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [TAG_W-1:0]  mem_req_tag;

    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              up_rsp_valid;
    logic              up_rsp_ready;
    logic [SRC_W-1:0]  up_rsp_src;
    logic [DATA_W-1:0] up_rsp_data;

    // slave: the tracker itself
    modport slave (
        input  up_req_valid,
        input  up_req_write,
        input  up_req_addr,
        input  up_req_data,
        input  up_req_src,
        output up_req_ready,
        output mem_req_valid,
        output mem_req_write,
        output mem_req_addr,
        output mem_req_data,
        output mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_tag,
        input  mem_rsp_data,
        output mem_rsp_ready,
        output up_rsp_valid,
        output up_rsp_src,
        output up_rsp_data,
        input  up_rsp_ready
    );

    // master: the mux and the memory port surrounding the tracker
    modport master (
        output up_req_valid,
        output up_req_write,
        output up_req_addr,
        output up_req_data,
        output up_req_src,
        input  up_req_ready,
        input  mem_req_valid,
        input  mem_req_write,
        input  mem_req_addr,
        input  mem_req_data,
        input  mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_tag,
        output mem_rsp_data,
        input  mem_rsp_ready,
        input  up_rsp_valid,
        input  up_rsp_src,
        input  up_rsp_data,
        output up_rsp_ready
    );
endinterface

// File: rtl/core_mem_tag_tracker.sv
// Swaps upstream source ids for local tags on the way to memory and
// restores them on responses, allowing out-of-order memory returns.
module core_mem_tag_tracker #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 64,
    parameter int  SRC_W  = 4,
    parameter int  TAGS   = 4,
    localparam int TAG_W  = $clog2(TAGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    core_mem_tag_tracker_if.slave  bus,
    output logic [TAG_W:0]         outstanding,
    output logic                   err_bad_tag
);

    logic                       any_free;
    logic [TAG_W-1:0]           free_tag;
    logic                       req_ready;
    logic                       req_fire;
    logic                       rsp_ready;
    logic                       rsp_fire;
    logic                       rsp_hit;
    logic                       rsp_good;

    logic [TAGS-1:0]            busy_q;
    logic [TAGS-1:0]            busy_d;
    logic [TAGS-1:0][SRC_W-1:0] src_q;
    logic [TAGS-1:0][SRC_W-1:0] src_d;
    logic [TAG_W:0]             cnt_q;
    logic [TAG_W:0]             cnt_d;
    logic                       err_q;
    logic                       err_d;

    logic                       mreq_valid_q;
    logic                       mreq_valid_d;
    logic                       mreq_write_q;
    logic                       mreq_write_d;
    logic [ADDR_W-1:0]          mreq_addr_q;
    logic [ADDR_W-1:0]          mreq_addr_d;
    logic [DATA_W-1:0]          mreq_data_q;
    logic [DATA_W-1:0]          mreq_data_d;
    logic [TAG_W-1:0]           mreq_tag_q;
    logic [TAG_W-1:0]           mreq_tag_d;

    logic                       ursp_valid_q;
    logic                       ursp_valid_d;
    logic [SRC_W-1:0]           ursp_src_q;
    logic [SRC_W-1:0]           ursp_src_d;
    logic [DATA_W-1:0]          ursp_data_q;
    logic [DATA_W-1:0]          ursp_data_d;

    // Lowest free tag, from the registered mask so a tag freed this
    // cycle only becomes allocatable next cycle.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    // Handshake qualifiers for both directions.
    always_comb begin
        req_ready = any_free && (!mreq_valid_q || bus.mem_req_ready);
        req_fire  = bus.up_req_valid && req_ready;
        rsp_ready = !ursp_valid_q || bus.up_rsp_ready;
        rsp_fire  = bus.mem_rsp_valid && rsp_ready;
        rsp_hit   = busy_q[bus.mem_rsp_tag];
        rsp_good  = rsp_fire && rsp_hit;
    end

    // Tag table: allocate on request accept, release on good response.
    // The allocated tag is never busy and the released one always is,
    // so both can happen in one cycle without conflict.
    always_comb begin
        busy_d = busy_q;
        src_d  = src_q;
        if (rsp_good) begin
            busy_d[bus.mem_rsp_tag] = 1'b0;
        end
        if (req_fire) begin
            busy_d[free_tag] = 1'b1;
            src_d[free_tag]  = bus.up_req_src;
        end
    end

    // Memory request output register.
    always_comb begin
        mreq_valid_d = mreq_valid_q;
        mreq_write_d = mreq_write_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_data_d  = mreq_data_q;
        mreq_tag_d   = mreq_tag_q;
        if (req_fire) begin
            mreq_valid_d = 1'b1;
            mreq_write_d = bus.up_req_write;
            mreq_addr_d  = bus.up_req_addr;
            mreq_data_d  = bus.up_req_data;
            mreq_tag_d   = free_tag;
        end else if (bus.mem_req_ready) begin
            mreq_valid_d = 1'b0;
        end
    end

    // Upstream response output register; bad-tag responses are
    // consumed without producing an upstream beat.
    always_comb begin
        ursp_valid_d = ursp_valid_q;
        ursp_src_d   = ursp_src_q;
        ursp_data_d  = ursp_data_q;
        if (rsp_good) begin
            ursp_valid_d = 1'b1;
            ursp_src_d   = src_q[bus.mem_rsp_tag];
            ursp_data_d  = bus.mem_rsp_data;
        end else if (bus.up_rsp_ready) begin
            ursp_valid_d = 1'b0;
        end
    end

    // Outstanding count tracks the busy mask; error flag is sticky.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (req_fire && !rsp_good) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!req_fire && rsp_good) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (rsp_fire && !rsp_hit) begin
            err_d = 1'b1;
        end
    end

    // State registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            src_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mreq_valid_q <= 1'b0;
            mreq_write_q <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
            mreq_tag_q   <= '0;
            ursp_valid_q <= 1'b0;
            ursp_src_q   <= '0;
            ursp_data_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            src_q        <= src_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_write_q <= mreq_write_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_data_q  <= mreq_data_d;
            mreq_tag_q   <= mreq_tag_d;
            ursp_valid_q <= ursp_valid_d;
            ursp_src_q   <= ursp_src_d;
            ursp_data_q  <= ursp_data_d;
        end
    end

    assign bus.up_req_ready  = req_ready;
    assign bus.mem_req_valid = mreq_valid_q;
    assign bus.mem_req_write = mreq_write_q;
    assign bus.mem_req_addr  = mreq_addr_q;
    assign bus.mem_req_data  = mreq_data_q;
    assign bus.mem_req_tag   = mreq_tag_q;
    assign bus.mem_rsp_ready = rsp_ready;
    assign bus.up_rsp_valid  = ursp_valid_q;
    assign bus.up_rsp_src    = ursp_src_q;
    assign bus.up_rsp_data   = ursp_data_q;
    assign outstanding       = cnt_q;
    assign err_bad_tag       = err_q;

endmodule

// File: tb/tb_core_mem_tag_tracker.sv
// Bench for core_mem_tag_tracker: directed table, hand-written
// corner sequences and a randomized run against a queue model.
module tb_core_mem_tag_tracker;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int SRC_W  = 4;
    localparam int TAGS   = 4;
    localparam int TAG_W  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [TAG_W:0] outstanding;
    logic           err_bad_tag;

    core_mem_tag_tracker_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .TAGS(TAGS)
    ) bus ();

    core_mem_tag_tracker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .TAGS(TAGS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .err_bad_tag (err_bad_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic              rv;
        logic [SRC_W-1:0]  rs;
        logic [ADDR_W-1:0] ra;
        logic              pv;
        logic [TAG_W-1:0]  pt;
        logic [DATA_W-1:0] pd;
        logic              e_rr;
        logic              e_mv;
        logic [TAG_W-1:0]  e_mt;
        logic [ADDR_W-1:0] e_ma;
        logic              e_uv;
        logic [SRC_W-1:0]  e_us;
        logic [DATA_W-1:0] e_ud;
        logic [TAG_W:0]    e_oc;
    } vec_t;

    vec_t tbl[26];

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;
    } mreq_t;

    typedef struct packed {
        logic [SRC_W-1:0]  s;
        logic [DATA_W-1:0] d;
    } ursp_t;

    bit               m_busy[TAGS];
    logic [SRC_W-1:0] m_src[TAGS];
    mreq_t            m_mq[$];
    ursp_t            m_uq[$];
    bit               m_err;
    int               issued[$];

    function automatic vec_t mk(
        input int rv, input int rs, input int ra,
        input int pv, input int pt, input longint pd,
        input int rr, input int mv, input int mt, input int ma,
        input int uv, input int us, input longint ud, input int oc
    );
        vec_t v;
        v.rv   = 1'(rv);
        v.rs   = SRC_W'(rs);
        v.ra   = ADDR_W'(ra);
        v.pv   = 1'(pv);
        v.pt   = TAG_W'(pt);
        v.pd   = DATA_W'(pd);
        v.e_rr = 1'(rr);
        v.e_mv = 1'(mv);
        v.e_mt = TAG_W'(mt);
        v.e_ma = ADDR_W'(ma);
        v.e_uv = 1'(uv);
        v.e_us = SRC_W'(us);
        v.e_ud = DATA_W'(ud);
        v.e_oc = (TAG_W+1)'(oc);
        return v;
    endfunction

    function automatic logic [127:0] pk(
        input logic rr, input logic mv, input logic [TAG_W-1:0] mt,
        input logic [ADDR_W-1:0] ma, input logic uv,
        input logic [SRC_W-1:0] us, input logic [DATA_W-1:0] ud,
        input logic [TAG_W:0] oc
    );
        return 128'({rr, mv, mt, ma, uv, us, ud, oc});
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        bus.up_req_valid  = 1'b0;
        bus.up_req_write  = 1'b0;
        bus.up_req_addr   = '0;
        bus.up_req_data   = '0;
        bus.up_req_src    = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_tag   = '0;
        bus.mem_rsp_data  = '0;
        bus.up_rsp_ready  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic req(input int src, input int addr);
        bus.up_req_valid = 1'b1;
        bus.up_req_src   = SRC_W'(src);
        bus.up_req_addr  = ADDR_W'(addr);
    endtask

    task automatic rsp(input int tag, input longint data);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = TAG_W'(tag);
        bus.mem_rsp_data  = DATA_W'(data);
    endtask

    task automatic run_table();
        logic [127:0] g;
        logic [127:0] e;
        for (int i = 0; i < 26; i++) begin
            bus.up_req_valid  = tbl[i].rv;
            bus.up_req_src    = tbl[i].rs;
            bus.up_req_addr   = tbl[i].ra;
            bus.up_req_write  = 1'b0;
            bus.mem_rsp_valid = tbl[i].pv;
            bus.mem_rsp_tag   = tbl[i].pt;
            bus.mem_rsp_data  = tbl[i].pd;
            bus.mem_req_ready = 1'b1;
            bus.up_rsp_ready  = 1'b1;
            #1;
            g = pk(bus.up_req_ready, bus.mem_req_valid,
                   bus.mem_req_tag & {TAG_W{bus.mem_req_valid}},
                   bus.mem_req_addr & {ADDR_W{bus.mem_req_valid}},
                   bus.up_rsp_valid,
                   bus.up_rsp_src & {SRC_W{bus.up_rsp_valid}},
                   bus.up_rsp_data & {DATA_W{bus.up_rsp_valid}},
                   outstanding);
            e = pk(tbl[i].e_rr, tbl[i].e_mv, tbl[i].e_mt, tbl[i].e_ma,
                   tbl[i].e_uv, tbl[i].e_us, tbl[i].e_ud, tbl[i].e_oc);
            chk($sformatf("vec%0d", i), g, e);
            step();
        end
        idle();
        #1;
        chk("table_err", 128'(err_bad_tag), 128'(0));
    endtask

    task automatic run_backpressure();
        do_reset();
        req(4, 'h400);
        #1;
        step();
        req(5, 'h410);
        #1;
        step();
        idle();
        #1;
        step();
        bus.up_rsp_ready = 1'b0;
        rsp(0, 'hA1);
        #1;
        chk("bp_rsp_rdy0", 128'(bus.mem_rsp_ready), 128'(1));
        step();
        rsp(1, 'hA2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_v", 128'(bus.up_rsp_valid), 128'(1));
            chk("bp_hold_s", 128'(bus.up_rsp_src), 128'(4));
            chk("bp_hold_d", 128'(bus.up_rsp_data), 128'('hA1));
            chk("bp_mrdy0", 128'(bus.mem_rsp_ready), 128'(0));
            step();
        end
        bus.up_rsp_ready = 1'b1;
        #1;
        chk("bp_mrdy1", 128'(bus.mem_rsp_ready), 128'(1));
        step();
        idle();
        #1;
        chk("bp_second", 128'({bus.up_rsp_valid, bus.up_rsp_src,
                               bus.up_rsp_data, outstanding}),
            128'({1'b1, 4'd5, 64'hA2, 3'd0}));
        step();
        chk("bp_drained", 128'(bus.up_rsp_valid), 128'(0));
    endtask

    task automatic run_bad_tag();
        do_reset();
        rsp(0, 'h77);
        #1;
        step();
        idle();
        #1;
        chk("empty_rsp", 128'({err_bad_tag, bus.up_rsp_valid, outstanding}),
            128'({1'b1, 1'b0, 3'd0}));
        do_reset();
        req(3, 'h500);
        #1;
        step();
        idle();
        #1;
        step();
        rsp(3, 'h55);
        #1;
        chk("bad_pre_err", 128'(err_bad_tag), 128'(0));
        chk("bad_pre_rdy", 128'(bus.mem_rsp_ready), 128'(1));
        step();
        idle();
        #1;
        chk("bad_post", 128'({err_bad_tag, bus.up_rsp_valid, outstanding}),
            128'({1'b1, 1'b0, 3'd1}));
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bad_sticky", 128'(err_bad_tag), 128'(1));
            step();
        end
        bus.mem_req_ready = 1'b0;
        req(6, 'h510);
        #1;
        step();
        idle();
        bus.mem_req_ready = 1'b0;
        #1;
        chk("mid_txn", 128'({bus.mem_req_valid, bus.mem_req_tag, outstanding}),
            128'({1'b1, 2'd1, 3'd2}));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 128'({bus.mem_req_valid, bus.up_rsp_valid,
                               outstanding, err_bad_tag,
                               bus.mem_req_tag, bus.mem_req_addr}),
            128'(0));
        do_reset();
    endtask

    task automatic run_random(input int n);
        bit  req_pend;
        bit  rsp_pend;
        int  cnt;
        int  t;
        int  k;
        bit  e_rr;
        bit  e_pr;
        do_reset();
        for (int i = 0; i < TAGS; i++) begin
            m_busy[i] = 1'b0;
            m_src[i]  = '0;
        end
        m_mq.delete();
        m_uq.delete();
        issued.delete();
        m_err    = 1'b0;
        req_pend = 1'b0;
        rsp_pend = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (!req_pend) begin
                bus.up_req_valid = ($urandom_range(0, 2) != 0);
                bus.up_req_write = 1'($urandom_range(0, 1));
                bus.up_req_addr  = $urandom;
                bus.up_req_data  = {$urandom, $urandom};
                bus.up_req_src   = SRC_W'($urandom_range(0, 15));
            end
            if (!rsp_pend) begin
                bus.mem_rsp_data = {$urandom, $urandom};
                if (issued.size() != 0 && $urandom_range(0, 3) != 0) begin
                    k = $urandom_range(0, issued.size() - 1);
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_tag   = TAG_W'(issued[k]);
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_tag   = TAG_W'($urandom_range(0, TAGS - 1));
                end else begin
                    bus.mem_rsp_valid = 1'b0;
                end
            end
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.up_rsp_ready  = ($urandom_range(0, 3) != 0);
            #1;
            cnt = 0;
            t = -1;
            for (int i = 0; i < TAGS; i++) begin
                if (m_busy[i]) cnt++;
                else if (t < 0) t = i;
            end
            e_rr = (cnt < TAGS) && (m_mq.size() == 0 || bus.mem_req_ready);
            e_pr = (m_uq.size() == 0) || bus.up_rsp_ready;
            chk("rnd_req_rdy", 128'(bus.up_req_ready), 128'(e_rr));
            chk("rnd_rsp_rdy", 128'(bus.mem_rsp_ready), 128'(e_pr));
            chk("rnd_mreq_v", 128'(bus.mem_req_valid), 128'(m_mq.size() != 0));
            if (m_mq.size() != 0) begin
                chk("rnd_mreq", 128'({bus.mem_req_write, bus.mem_req_addr,
                                      bus.mem_req_data, bus.mem_req_tag}),
                    128'(m_mq[0]));
            end
            chk("rnd_ursp_v", 128'(bus.up_rsp_valid), 128'(m_uq.size() != 0));
            if (m_uq.size() != 0) begin
                chk("rnd_ursp", 128'({bus.up_rsp_src, bus.up_rsp_data}),
                    128'(m_uq[0]));
            end
            chk("rnd_outst", 128'(outstanding), 128'(cnt));
            chk("rnd_err", 128'(err_bad_tag), 128'(m_err));
            if (m_mq.size() != 0 && bus.mem_req_ready) begin
                issued.push_back(int'(m_mq[0].t));
                void'(m_mq.pop_front());
            end
            if (m_uq.size() != 0 && bus.up_rsp_ready) begin
                void'(m_uq.pop_front());
            end
            rsp_pend = bus.mem_rsp_valid && !e_pr;
            if (bus.mem_rsp_valid && e_pr) begin
                for (int j = 0; j < issued.size(); j++) begin
                    if (issued[j] == int'(bus.mem_rsp_tag)) begin
                        issued.delete(j);
                        break;
                    end
                end
                if (m_busy[bus.mem_rsp_tag]) begin
                    m_uq.push_back({m_src[bus.mem_rsp_tag], bus.mem_rsp_data});
                    m_busy[bus.mem_rsp_tag] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            req_pend = bus.up_req_valid && !e_rr;
            if (bus.up_req_valid && e_rr) begin
                m_busy[t] = 1'b1;
                m_src[t]  = bus.up_req_src;
                m_mq.push_back({bus.up_req_write, bus.up_req_addr,
                                bus.up_req_data, TAG_W'(t)});
            end
            step();
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 'h100, 0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     0);
        tbl[1]  = mk(0, 0, 0,     0, 0, 0,     1, 1, 0, 'h100, 0, 0, 0,     1);
        tbl[2]  = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     1);
        tbl[3]  = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     1);
        tbl[4]  = mk(0, 0, 0,     1, 0, 'hDEAD, 1, 0, 0, 0,    0, 0, 0,     1);
        tbl[5]  = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     1, 1, 'hDEAD, 0);
        tbl[6]  = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     0);
        tbl[7]  = mk(1, 1, 'h210, 0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     0);
        tbl[8]  = mk(1, 2, 'h220, 0, 0, 0,     1, 1, 0, 'h210, 0, 0, 0,     1);
        tbl[9]  = mk(1, 3, 'h230, 0, 0, 0,     1, 1, 1, 'h220, 0, 0, 0,     2);
        tbl[10] = mk(1, 1, 'h240, 0, 0, 0,     1, 1, 2, 'h230, 0, 0, 0,     3);
        tbl[11] = mk(1, 5, 'h250, 0, 0, 0,     0, 1, 3, 'h240, 0, 0, 0,     4);
        tbl[12] = mk(1, 5, 'h250, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0,     4);
        tbl[13] = mk(0, 0, 0,     1, 2, 'h22,  0, 0, 0, 0,     0, 0, 0,     4);
        tbl[14] = mk(0, 0, 0,     1, 0, 'h20,  1, 0, 0, 0,     1, 3, 'h22,  3);
        tbl[15] = mk(0, 0, 0,     1, 3, 'h23,  1, 0, 0, 0,     1, 1, 'h20,  2);
        tbl[16] = mk(0, 0, 0,     1, 1, 'h21,  1, 0, 0, 0,     1, 1, 'h23,  1);
        tbl[17] = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     1, 2, 'h21,  0);
        tbl[18] = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     0);
        tbl[19] = mk(1, 6, 'h300, 0, 0, 0,     1, 0, 0, 0,     0, 0, 0,     0);
        tbl[20] = mk(1, 7, 'h310, 0, 0, 0,     1, 1, 0, 'h300, 0, 0, 0,     1);
        tbl[21] = mk(1, 8, 'h320, 0, 0, 0,     1, 1, 1, 'h310, 0, 0, 0,     2);
        tbl[22] = mk(1, 9, 'h330, 0, 0, 0,     1, 1, 2, 'h320, 0, 0, 0,     3);
        tbl[23] = mk(1, 10, 'h340, 1, 1, 'h31, 0, 1, 3, 'h330, 0, 0, 0,     4);
        tbl[24] = mk(1, 10, 'h340, 0, 0, 0,    1, 0, 0, 0,     1, 7, 'h31,  3);
        tbl[25] = mk(0, 0, 0,     0, 0, 0,     0, 1, 1, 'h340, 0, 0, 0,     4);

        idle();
        #3;
        chk("rst_mreq_v", 128'(bus.mem_req_valid), 128'(0));
        chk("rst_ursp_v", 128'(bus.up_rsp_valid), 128'(0));
        chk("rst_outst", 128'(outstanding), 128'(0));
        chk("rst_err", 128'(err_bad_tag), 128'(0));

        do_reset();
        run_table();
        run_backpressure();
        run_bad_tag();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
